// File: rtl/alu_issue_queue.sv
// Out-of-order ALU issue queue: compacting age-ordered entries, operand wakeup from the ALU
// result broadcast, oldest-ready select. Optional same-cycle bypass under ALU_IQ_FASTPATH_EN.
module alu_issue_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAGW  = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_flush,
  input  logic            i_driveFromDispatch,
  output logic            o_freeToDispatch,
  input  logic [3:0]      i_controlFromDispatch_4,
  input  logic [TAGW-1:0] i_tagFromDispatch_4,
  input  logic [4:0]      i_areg_5,
  input  logic            i_src1Ready,
  input  logic [TAGW-1:0] i_src1Tag_4,
  input  logic [31:0]     i_src1Value_32,
  input  logic            i_src2Ready,
  input  logic [TAGW-1:0] i_src2Tag_4,
  input  logic [31:0]     i_src2Value_32,
  input  logic            i_driveFromAlu,
  input  logic [31:0]     i_resultFromAlu_32,
  input  logic [TAGW-1:0] i_indexFromAlu_4,
  output logic            o_driveToAlu,
  input  logic            i_freeFromAlu,
  output logic [3:0]      o_controlToAlu_4,
  output logic [TAGW-1:0] o_tagToAlu_4,
  output logic [31:0]     o_oprand1ToAlu_32,
  output logic [31:0]     o_oprand2ToAlu_32,
  output logic [4:0]      o_areg_5
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic            valid;
    logic [3:0]      control;
    logic [TAGW-1:0] tag;
    logic [4:0]      areg;
    logic            src1Ready;
    logic [TAGW-1:0] src1Tag;
    logic [31:0]     src1Value;
    logic            src2Ready;
    logic [TAGW-1:0] src2Tag;
    logic [31:0]     src2Value;
  } iqEntry_t;

  iqEntry_t        entryQ [DEPTH];
  iqEntry_t        entryD [DEPTH];
  logic [CntW-1:0] countQ, countD;

  iqEntry_t newEntry;
  logic     dispatchFire;
  logic     selFound;
  int       selIdx;
  logic     fastValid;
  logic     issueStored;
  logic     fastTaken;

  assign o_freeToDispatch = (countQ < CntW'(DEPTH));
  assign dispatchFire     = i_driveFromDispatch & o_freeToDispatch;

  // Incoming entry, with a same-cycle broadcast folded in so no wakeup is lost.
  always_comb begin
    newEntry           = '0;
    newEntry.valid     = 1'b1;
    newEntry.control   = i_controlFromDispatch_4;
    newEntry.tag       = i_tagFromDispatch_4;
    newEntry.areg      = i_areg_5;
    newEntry.src1Ready = i_src1Ready;
    newEntry.src1Tag   = i_src1Tag_4;
    newEntry.src1Value = i_src1Value_32;
    newEntry.src2Ready = i_src2Ready;
    newEntry.src2Tag   = i_src2Tag_4;
    newEntry.src2Value = i_src2Value_32;
    if (i_driveFromAlu && !i_src1Ready && (i_src1Tag_4 == i_indexFromAlu_4)) begin
      newEntry.src1Ready = 1'b1;
      newEntry.src1Value = i_resultFromAlu_32;
    end
    if (i_driveFromAlu && !i_src2Ready && (i_src2Tag_4 == i_indexFromAlu_4)) begin
      newEntry.src2Ready = 1'b1;
      newEntry.src2Value = i_resultFromAlu_32;
    end
  end

  // Oldest-ready select; descending scan so the lowest ready slot wins.
  always_comb begin
    selFound          = 1'b0;
    selIdx            = 0;
    fastValid         = 1'b0;
    o_controlToAlu_4  = '0;
    o_tagToAlu_4      = '0;
    o_oprand1ToAlu_32 = '0;
    o_oprand2ToAlu_32 = '0;
    o_areg_5          = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (entryQ[i].valid && entryQ[i].src1Ready && entryQ[i].src2Ready) begin
        selFound          = 1'b1;
        selIdx            = i;
        o_controlToAlu_4  = entryQ[i].control;
        o_tagToAlu_4      = entryQ[i].tag;
        o_oprand1ToAlu_32 = entryQ[i].src1Value;
        o_oprand2ToAlu_32 = entryQ[i].src2Value;
        o_areg_5          = entryQ[i].areg;
      end
    end
`ifdef ALU_IQ_FASTPATH_EN
    if (!selFound && dispatchFire && newEntry.src1Ready && newEntry.src2Ready) begin
      fastValid         = 1'b1;
      o_controlToAlu_4  = newEntry.control;
      o_tagToAlu_4      = newEntry.tag;
      o_oprand1ToAlu_32 = newEntry.src1Value;
      o_oprand2ToAlu_32 = newEntry.src2Value;
      o_areg_5          = newEntry.areg;
    end
`endif
    o_driveToAlu = selFound | fastValid;
  end

  assign issueStored = selFound & i_freeFromAlu;
  assign fastTaken   = fastValid & i_freeFromAlu;

  // Order matters: wakeup, then compaction for issue, then enqueue at the post-issue tail.
  always_comb begin
    entryD = entryQ;
    countD = countQ;
    if (i_driveFromAlu) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entryD[i].valid && !entryD[i].src1Ready &&
            (entryD[i].src1Tag == i_indexFromAlu_4)) begin
          entryD[i].src1Ready = 1'b1;
          entryD[i].src1Value = i_resultFromAlu_32;
        end
        if (entryD[i].valid && !entryD[i].src2Ready &&
            (entryD[i].src2Tag == i_indexFromAlu_4)) begin
          entryD[i].src2Ready = 1'b1;
          entryD[i].src2Value = i_resultFromAlu_32;
        end
      end
    end
    if (issueStored) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= selIdx) entryD[i] = entryD[i+1];
      end
      entryD[DEPTH-1] = '0;
      countD          = countD - CntW'(1);
    end
    if (dispatchFire && !fastTaken) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CntW'(i) == countD) entryD[i] = newEntry;
      end
      countD = countD + CntW'(1);
    end
    if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) entryD[i] = '0;
      countD = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) entryQ[i] <= '0;
      countQ <= '0;
    end else begin
      entryQ <= entryD;
      countQ <= countD;
    end
  end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Out-of-order issue queue directly upstream of the ALU. Holds up to DEPTH dispatched ALU ops.
- Captures source operands from the ALU result broadcast (result + 4-bit tag), then issues the oldest fully-ready op over a drive/free handshake.
- Its outputs map one-to-one onto the ALU's issue-side inputs (control, tag, operand1, operand2, areg).

Parameters:
DEPTH, 4, number of queue entries (2..8)
TAGW, 4, width of instruction tag / source-tag fields

Ports:
clk  input  1  clock; all state changes on rising edge
rstn  input  1  asynchronous active-low reset
i_flush  input  1  synchronous clear of all entries
i_driveFromDispatch  input  1  dispatch valid
o_freeToDispatch  output  1  queue can accept (count < DEPTH)
i_controlFromDispatch_4  input  4  ALU op code, passed through unchanged
i_tagFromDispatch_4  input  TAGW  destination tag of op
i_areg_5  input  5  architectural destination register
i_src1Ready  input  1  operand1 value valid at dispatch
i_src1Tag_4  input  TAGW  producer tag for operand1 when not ready
i_src1Value_32  input  32  operand1 value when ready
i_src2Ready  input  1  operand2 value valid at dispatch
i_src2Tag_4  input  TAGW  producer tag for operand2 when not ready
i_src2Value_32  input  32  operand2 value/immediate when ready
i_driveFromAlu  input  1  result broadcast valid
i_resultFromAlu_32  input  32  broadcast result
i_indexFromAlu_4  input  TAGW  broadcast tag
o_driveToAlu  output  1  issue valid
i_freeFromAlu  input  1  ALU can accept
o_controlToAlu_4  output  4  issued op code
o_tagToAlu_4  output  TAGW  issued tag
o_oprand1ToAlu_32  output  32  issued operand1
o_oprand2ToAlu_32  output  32  issued operand2
o_areg_5  output  5  issued destination register

Behaviour:
- Handshakes:
  - Dispatch transfer: i_driveFromDispatch & o_freeToDispatch at clk edge.
  - Issue transfer: o_driveToAlu & i_freeFromAlu at clk edge.
  - o_freeToDispatch = (count < DEPTH), from registered count only. An issue in the same cycle does not free a slot until the next cycle.
- Storage: compacting age-ordered array, slot 0 oldest. Each entry holds valid, control, tag, areg, and per source {ready, tag, value}.
- Enqueue: new entry written at slot count (after compaction for any same-cycle issue).
- Select: lowest-index entry with valid & src1.ready & src2.ready drives the o_* outputs combinationally. o_driveToAlu = 1 iff such an entry exists.
- Idle outputs: when o_driveToAlu = 0, all data outputs = 0.
- Issue holds while i_freeFromAlu = 0: the selected entry and its outputs stay stable. The selection may change only if an older entry becomes ready.
- Remove on issue: the issued entry is removed and higher slots shift down by one in the same edge.
- Wakeup: on an edge with i_driveFromAlu = 1, every valid entry source with ready = 0 and tag == i_indexFromAlu_4 captures i_resultFromAlu_32 and sets ready. The entry is eligible the next cycle.
- Dispatch/broadcast collision: a dispatched source with ready = 0 whose tag equals a same-cycle broadcast tag is written as ready with the broadcast value. No lost wakeup.
- Simultaneous events: dispatch, issue and wakeup in one cycle all take effect. count' = count + dispatch − issue.
- Latency: dispatch with both sources ready → o_driveToAlu earliest the next cycle. Wakeup → issue earliest the next cycle.
- i_flush: all valid cleared and count = 0 next edge. Flush has priority over dispatch and wakeup. An issue in the flush cycle still completes on the ALU side.
- Reset (rstn = 0, async):
  - All entries invalid, all fields 0, count = 0.
  - o_driveToAlu = 0, data outputs = 0, o_freeToDispatch = 1.
  - Reset mid-handshake discards the pending issue.
- Full: count == DEPTH → o_freeToDispatch = 0. A dispatch attempted while full is ignored; no state change.

Optional Feature:
ALU_IQ_FASTPATH_EN
- Defined: when no stored entry is ready and the incoming dispatch has both sources ready (directly or via collision wakeup), it is presented on the o_* outputs in the same cycle, with o_driveToAlu = 1.
  - If i_freeFromAlu = 1, it is consumed and never enqueued (latency 0).
  - Otherwise it is enqueued normally. o_freeToDispatch still gates the dispatch.
- Undefined: minimum dispatch-to-issue latency is 1 cycle; outputs derive only from stored entries.

Test Plan:
- Reset, then dispatch control=4'b1111, tag=3, src1=5, src2=7 (both ready), i_freeFromAlu=1 → next cycle o_driveToAlu=1, op1=5, op2=7, tag=3; following cycle o_driveToAlu=0, count=0.
- Dispatch tag=2 with src1 waiting on tag 9, then broadcast tag=9 value 0x1234 → next cycle issue with op1=0x1234; no issue before the broadcast.
- Dispatch tags 1, 2, 3 (only tag 2 ready); i_freeFromAlu=0 for 3 cycles → tag 2 outputs held stable; after release, issue tag 2; count 3→2.
- Fill 4 entries with unready sources → o_freeToDispatch=0; a 5th dispatch is ignored; one wakeup+issue restores free the cycle after the issue.
- Dispatch waiting on tag 5 in the same cycle as broadcast tag 5 value 0xAA → op captured; issues the next cycle with value 0xAA.
- Assert i_flush with 3 entries, and separately assert rstn low mid-issue → queue empty, o_driveToAlu=0, o_freeToDispatch=1.
